ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. Registers the decode-to-execute bus and computes the ALU result. Generates data-SRAM requests for loads and stores, and forwards its result back to decode. Contains HI/LO and an iterative multiply/divide unit that requests a pipeline stall while busy.

## Interface
- `MULDIV_CYCLES`, default 32: iteration count for the multiply/divide datapath (one bit per cycle).
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in `StallBus`: controller stall vector; bit 2 is EX, bit 3 is MEM.
- `id_to_ex_bus` in `ID_TO_EX_WD` (163), packed MSB→LSB:
  - `data_ram_readen[4]`, `pc[32]`, `inst[32]`, `alu_op[12]`
  - `sel_alu_src1[3]`, `sel_alu_src2[4]`
  - `data_ram_en`, `data_ram_wen[4]`
  - `rf_we`, `rf_waddr[5]`, `sel_rf_res`
  - `rdata1[32]`, `rdata2[32]`
- `ex_to_mem_bus` out `EX_TO_MEM_WD` (80), packed MSB→LSB: `data_ram_readen`, `pc`, `data_ram_en`, `data_ram_wen`, `sel_rf_res`, `rf_we`, `rf_waddr`, `ex_result`.
- `ex_to_id_bus` out `EX_TO_ID_FW` (38): `{rf_we, rf_waddr, ex_result}`.
- `ex_is_load` out 1: the EX instruction is a load.
- `stallreq_for_ex` out 1: multiply/divide in progress.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32: data memory request.

## Operation
- **Input register**
  - Reset (`rst`=0): cleared to 0.
  - `stall[2]`=Stop and `stall[3]`=NoStop: loads all-zero (bubble).
  - `stall[2]`=NoStop: loads `id_to_ex_bus`.
  - Otherwise: holds.
- **src1 select** (one-hot `sel_alu_src1`): rdata1 / pc / zero-extended `inst[10:6]`.
- **src2 select** (one-hot `sel_alu_src2`): rdata2 / sign-extended imm / 32'd8 / zero-extended imm.
- **ALU ops**, `alu_op` MSB→LSB:
  - add, sub: mod 2^32, no overflow trap.
  - slt (signed), sltu.
  - and, nor, or, xor.
  - sll, srl, sra: shift src2 by src1[4:0].
  - lui: `{src2[15:0], 16'b0}`.
  - Exactly one op is active; none active → result 0.
- **Memory request**
  - `data_sram_en = data_ram_en`.
  - Address = rdata1 + sign-extended `inst[15:0]`.
  - `data_sram_wen = data_ram_wen`; `data_sram_wdata = rdata2`.
  - All four outputs are forced to 0 while `stall[2]`=Stop, so a stalled EX never issues a memory request.
- **`ex_is_load`** = `data_ram_en & |data_ram_readen`.
- **Multiply/divide decode**: opcode 0 with
  - func 0x18/0x19: mult/multu.
  - func 0x1A/0x1B: div/divu.
  - func 0x10/0x12: mfhi/mflo.
  - func 0x11/0x13: mthi/mtlo.
- **mfhi/mflo**: `ex_result` = HI/LO. Register write enable is forced to 1 and the destination is `inst[15:11]`.
- **mthi/mtlo**: write rdata1 into HI/LO at the clock edge, only when `stall[2]`=NoStop.
- **State machine**: IDLE → BUSY → DONE → IDLE.
  - IDLE→BUSY: a mult/div instruction is present. Latch operands; signed variants use absolute values plus sign flags; counter = 0.
  - BUSY:
    - Multiply: shift-add, one step per cycle.
    - Divide: restoring, one quotient bit per cycle.
    - After `MULDIV_CYCLES` steps, go to DONE and apply sign correction.
  - DONE:
    - Multiply: `{HI, LO}` = 64-bit product.
    - Divide: LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
    - DONE→IDLE when `stall[2]`=NoStop.
- **Divide by zero**: LO = 32'hFFFF_FFFF, HI = dividend, with the same latency as a normal divide.
- **`stallreq_for_ex`** = mult/div present & state≠DONE (combinational).
- **Reset mid-operation**: FSM returns to IDLE; counter, HI and LO clear immediately and asynchronously.

## Timing
- ALU, address, and forward paths are combinational from the input register: zero extra latency.
- **Mult/div occupancy**: the instruction enters EX at cycle 0.
  - BUSY covers cycles 1–32.
  - DONE is cycle 33, with HI/LO valid from cycle 34.
  - `stallreq_for_ex` is high for cycles 0–32 and low at cycle 33.
- An mfhi immediately following a mult/div sees the final HI, because it cannot enter EX before DONE.
- **Reset values of outputs**: all buses 0, `data_sram_*` 0, `ex_is_load` 0, `stallreq_for_ex` 0.

## Configuration
- `EX_MULDIV_EN` defined: multiply/divide FSM, HI/LO, and the mf/mt instructions are compiled in.
- Undefined:
  - Those instructions execute as no-ops with `rf_we`=0.
  - `stallreq_for_ex` is tied to 0.
  - No HI/LO flops exist.

## Structure
- `lib/defines.vh`: `ID_TO_EX_WD`, `EX_TO_MEM_WD`, `EX_TO_ID_FW`, `StallBus`, `Stop`/`NoStop`, the multiply/divide func codes, and FSM state encodings.
- One sub-module: `muldiv_iter`. It contains the FSM, counter, and iterative datapath, and has ports start/signed/op/a/b → busy/done/hi/lo.

## Test plan
- ori with rdata1=0x0000_F000, imm=0x00FF → `ex_result`=0x0000_F0FF; `ex_to_id_bus` rf_we=1 with the rt address.
- lw base rdata1=0x1000, offset=0xFFFC → `data_sram_addr`=0x0FFC, `data_sram_en`=1, `ex_is_load`=1.
- div −7 / 2 → `stallreq_for_ex` high for exactly 33 cycles; then LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- multu 0xFFFF_FFFF × 2 → HI=1, LO=0xFFFF_FFFE; a following mfhi gives `ex_result`=1.
- divu by 0 with dividend 5 → LO=0xFFFF_FFFF, HI=5.
- Reset asserted at BUSY cycle 10 → `stallreq_for_ex`=0, HI=LO=0, state IDLE; `stall[2]`=Stop & `stall[3]`=NoStop → next bus all zero.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, multiply/divide function codes and the
// multiply/divide FSM state encoding for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 163;
    localparam int EX_TO_MEM_WD = 80;
    localparam int EX_TO_ID_FW  = 38;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle. Signed operations run on magnitudes and are corrected
// combinationally while in DONE. Divide by zero falls out of the restoring
// algorithm as quotient all-ones and remainder equal to the dividend.
module muldiv_iter
    import ex_stage_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic        op,
    input  logic        ack,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(MULDIV_CYCLES) + 1;

    md_state_e     state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   r_hi, r_lo, r_b;
    logic          is_div, neg_q, neg_r, b_zero;
    logic          last;
    logic [32:0]   add_sum;
    logic [33:0]   diff;
    logic [31:0]   step_hi, step_lo;
    logic [63:0]   prod;

    assign last      = (cnt == CW'(MULDIV_CYCLES - 1));
    assign busy      = (state == MD_BUSY);
    assign done      = (state == MD_DONE);
    assign state_dbg = state;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    // FSM next state: DONE is held until EX is allowed to advance
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (last)  state_nxt = MD_DONE;
            MD_DONE: if (ack)   state_nxt = MD_IDLE;
            default:            state_nxt = MD_IDLE;
        endcase
    end

    // One iteration of the shared datapath ({r_hi, r_lo} is product or rem/quot)
    always_comb begin
        add_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
        diff    = {1'b0, r_hi, r_lo[31]} - {2'b00, r_b};
        if (is_div) begin
            if (!diff[33]) begin
                step_hi = diff[31:0];
                step_lo = {r_lo[30:0], 1'b1};
            end else begin
                step_hi = {r_hi[30:0], r_lo[31]};
                step_lo = {r_lo[30:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[32:1];
            step_lo = {add_sum[0], r_lo[31:1]};
        end
    end

    // Operand latch on start, then one step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_b    <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            cnt    <= '0;
            r_hi   <= 32'd0;
            r_lo   <= (sgn && a[31]) ? -a : a;
            r_b    <= (sgn && b[31]) ? -b : b;
            is_div <= op;
            neg_q  <= sgn & (a[31] ^ b[31]);
            neg_r  <= sgn & a[31];
            b_zero <= (b == 32'd0);
        end else if (state == MD_BUSY) begin
            cnt  <= cnt + CW'(1);
            r_hi <= step_hi;
            r_lo <= step_lo;
        end
    end

    assign prod = neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};

    // Sign correction; a zero divisor keeps the raw all-ones quotient
    always_comb begin
        if (is_div) begin
            hi = neg_r ? -r_hi : r_hi;
            lo = (neg_q && !b_zero) ? -r_lo : r_lo;
        end else begin
            hi = prod[63:32];
            lo = prod[31:0];
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX input register, ALU, data SRAM request,
// forwarding bus to decode. Define EX_MULDIV_EN to compile in HI/LO, the
// iterative multiply/divide unit and the mfhi/mflo/mthi/mtlo instructions.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_FW-1:0]  ex_to_id_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    logic [ID_TO_EX_WD-1:0] bus_r;
    logic [3:0]  data_ram_readen, data_ram_wen, sel_alu_src2;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic        data_ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    logic [31:0] imm_sext, imm_zext, src1, src2, alu_res, ex_result;
    logic        rf_we_eff, ex_stop, is_special;
    logic [4:0]  waddr_eff;
    logic [5:0]  func;

    // ID/EX register: bubble when EX stalls but MEM advances, else load or hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      bus_r <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP) bus_r <= '0;
        else if (stall[2] == NO_STOP)                  bus_r <= id_to_ex_bus;
    end

    assign {data_ram_readen, pc, inst, alu_op, sel_alu_src1, sel_alu_src2,
            data_ram_en, data_ram_wen, rf_we, rf_waddr, sel_rf_res,
            rdata1, rdata2} = bus_r;

    assign imm_sext   = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext   = {16'd0, inst[15:0]};
    assign is_special = (inst[31:26] == 6'd0);
    assign func       = inst[5:0];

    assign src1 = ({32{sel_alu_src1[0]}} & rdata1)
                | ({32{sel_alu_src1[1]}} & pc)
                | ({32{sel_alu_src1[2]}} & {27'd0, inst[10:6]});
    assign src2 = ({32{sel_alu_src2[0]}} & rdata2)
                | ({32{sel_alu_src2[1]}} & imm_sext)
                | ({32{sel_alu_src2[2]}} & 32'd8)
                | ({32{sel_alu_src2[3]}} & imm_zext);

    // ALU: one-hot op select, zero when no op is active
    always_comb begin
        alu_res = 32'd0;
        if (alu_op[11]) alu_res = src1 + src2;
        if (alu_op[10]) alu_res = src1 - src2;
        if (alu_op[9])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_res = {31'd0, src1 < src2};
        if (alu_op[7])  alu_res = src1 & src2;
        if (alu_op[6])  alu_res = ~(src1 | src2);
        if (alu_op[5])  alu_res = src1 | src2;
        if (alu_op[4])  alu_res = src1 ^ src2;
        if (alu_op[3])  alu_res = src2 << src1[4:0];
        if (alu_op[2])  alu_res = src2 >> src1[4:0];
        if (alu_op[1])  alu_res = $unsigned($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = {src2[15:0], 16'd0};
    end

    // A stalled EX never presents a memory request
    assign ex_stop         = (stall[2] == STOP);
    assign data_sram_en    = ex_stop ? 1'b0  : data_ram_en;
    assign data_sram_wen   = ex_stop ? 4'd0  : data_ram_wen;
    assign data_sram_addr  = ex_stop ? 32'd0 : rdata1 + imm_sext;
    assign data_sram_wdata = ex_stop ? 32'd0 : rdata2;
    assign ex_is_load      = data_ram_en & (|data_ram_readen);

`ifdef EX_MULDIV_EN
    logic        md_mul, md_div, md_sgn, md_busy, md_done;
    logic        inst_mfhi, inst_mflo, inst_mthi, inst_mtlo;
    logic [31:0] md_hi, md_lo, hi_r, lo_r;
    logic [1:0]  md_state_unused;
    logic        unused_bits;

    assign md_mul    = is_special && (func == FUNC_MULT || func == FUNC_MULTU);
    assign md_div    = is_special && (func == FUNC_DIV  || func == FUNC_DIVU);
    assign md_sgn    = (func == FUNC_MULT || func == FUNC_DIV);
    assign inst_mfhi = is_special && (func == FUNC_MFHI);
    assign inst_mflo = is_special && (func == FUNC_MFLO);
    assign inst_mthi = is_special && (func == FUNC_MTHI);
    assign inst_mtlo = is_special && (func == FUNC_MTLO);

    muldiv_iter #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_mul | md_div),
        .sgn       (md_sgn),
        .op        (md_div),
        .ack       (stall[2] == NO_STOP),
        .a         (rdata1),
        .b         (rdata2),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .state_dbg (md_state_unused)
    );

    assign stallreq_for_ex = (md_mul | md_div) & ~md_done;

    // HI/LO: result capture in DONE, mthi/mtlo only when EX advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (md_done) begin
            hi_r <= md_hi;
            lo_r <= md_lo;
        end else if (stall[2] == NO_STOP) begin
            if (inst_mthi) hi_r <= rdata1;
            if (inst_mtlo) lo_r <= rdata1;
        end
    end

    // Result and destination: mfhi/mflo always write rd
    always_comb begin
        ex_result = alu_res;
        rf_we_eff = rf_we;
        waddr_eff = rf_waddr;
        if (inst_mfhi || inst_mflo) begin
            ex_result = inst_mfhi ? hi_r : lo_r;
            rf_we_eff = 1'b1;
            waddr_eff = inst[15:11];
        end
    end

    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], md_busy, md_state_unused};
`else
    logic md_any;
    logic unused_bits;

    assign md_any = is_special && (func inside {FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
                                                FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU});
    assign stallreq_for_ex = 1'b0;
    assign ex_result       = alu_res;
    assign rf_we_eff       = rf_we & ~md_any;
    assign waddr_eff       = rf_waddr;
    assign unused_bits     = ^{stall[5:4], stall[1:0], inst[25:16], MULDIV_CYCLES[0]};
`endif

    assign ex_to_mem_bus = {data_ram_readen, pc, data_ram_en, data_ram_wen,
                            sel_rf_res, rf_we_eff, waddr_eff, ex_result};
    assign ex_to_id_bus  = {rf_we_eff, waddr_eff, ex_result};

endmodule
